mmio_pwm_responder: RTL and testbench

Memory-mapped peripheral that answers the processor's data-side loads and stores in the high address window and drives the board `led`, `red`, `green`, `blue` outputs through 8-bit PWM. It also provides a free-running millisecond counter that firmware reads for delays. It sits beside data memory on the processor's data bus: the address decoder routes accesses in its window here, and its `read_data` feeds the load write-back path.

---
 rtl/mmio_pkg.sv | 35 +++
 rtl/pwm_channel.sv | 35 +++
 rtl/mmio_pwm_responder.sv | 163 ++++++++++++++++
 tb/tb_mmio_pwm_responder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO PWM responder: register offsets, RV32I load/store
// size codes, the duty byte type and a byte-lane merge helper.
// Latency: n/a (package). Backpressure: n/a.
package mmio_pkg;

  // Register offsets within the 256-byte window (word aligned)
  localparam logic [7:0] OFF_LED_DUTY = 8'h00;
  localparam logic [7:0] OFF_RGB_DUTY = 8'h04;
  localparam logic [7:0] OFF_PRESCALE = 8'h08;
  localparam logic [7:0] OFF_MILLIS   = 8'h0C;

  // RV32I funct3 encodings for loads and stores
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef logic [7:0] duty_t;

  // Replace the byte lanes of old_word selected by be with those of new_word
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*8 +: 8] = be[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow duty (firmware-visible) and active duty reloaded on period wrap.
// Latency: shadow updates the edge after a write; active takes shadow on the pwm_cnt 255->0 edge.
// Backpressure: none; writes always accepted.
// Ports: clk/reset; duty_we/duty_wdata write the shadow; wrap marks the period-end edge;
//        pwm_cnt is the shared step counter; shadow is read back; pwm_out is the output.
module pwm_channel
  import mmio_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  duty_we,
  input  duty_t duty_wdata,
  input  logic  wrap,
  input  duty_t pwm_cnt,
  output duty_t shadow,
  output logic  pwm_out
);

  duty_t active;

  // On a wrap coinciding with a write, active takes the pre-write shadow value,
  // so the new duty starts one full period later.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (duty_we) shadow <= duty_wdata;
      if (wrap)    active <= shadow;
    end
  end

  assign pwm_out = (pwm_cnt < active);

endmodule

// File: rtl/mmio_pwm_responder.sv
// Data-bus MMIO peripheral: LED/RGB PWM duty registers, PWM prescaler and a millisecond counter.
// Latency: loads are combinational in the access cycle; stores are visible the cycle after their edge.
// Backpressure: none; every access in the window completes in a single cycle.
// Ports: clk/reset (sync, active-high); mem_read/mem_write/address/funct3/write_data from the core;
//        read_data load result (extended); led/red/green/blue PWM outputs.
module mmio_pwm_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FF00,
  parameter int          CLK_FREQ_HZ = 12_000_000
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [2:0]  funct3,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam logic [31:0] TICK_LAST = 32'(CLK_FREQ_HZ / 1000 - 1);

  logic        hit;
  logic [7:0]  reg_off;
  logic [31:0] reg_word;
  logic [3:0]  be;
  logic [31:0] wd;
  logic        wr_en;
  logic [31:0] merged;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  duty_t       led_shadow, red_shadow, green_shadow, blue_shadow;
  logic [15:0] prescale_q;
  logic [15:0] pre_cnt;
  duty_t       pwm_cnt;
  logic [31:0] millis_q;
  logic [31:0] tick_cnt;

  logic        pre_wrap, pwm_wrap, tick_wrap;
  logic        led_we, rgb_we, prescale_we, millis_we;

  assign hit     = (address[31:8] == BASE_ADDR[31:8]);
  assign reg_off = {address[7:2], 2'b00};

  // Current contents of the addressed register; unimplemented bits read 0
  always_comb begin
    reg_word = '0;
    case (reg_off)
      OFF_LED_DUTY: reg_word = {24'h0, led_shadow};
      OFF_RGB_DUTY: reg_word = {8'h0, blue_shadow, green_shadow, red_shadow};
      OFF_PRESCALE: reg_word = {16'h0, prescale_q};
      OFF_MILLIS:   reg_word = millis_q;
      default:      reg_word = '0;
    endcase
  end

  // Store lane enables; misaligned or unknown sizes leave be at 0 so nothing commits
  always_comb begin
    be = '0;
    wd = '0;
    case (funct3)
      F3_SB: begin
        be = 4'b0001 << address[1:0];
        wd = {4{write_data[7:0]}};
      end
      F3_SH: begin
        if (!address[0]) begin
          be = address[1] ? 4'b1100 : 4'b0011;
          wd = {2{write_data[15:0]}};
        end
      end
      F3_SW: begin
        if (address[1:0] == 2'b00) begin
          be = 4'hF;
          wd = write_data;
        end
      end
      default: ;
    endcase
  end

  assign wr_en  = mem_write && hit && (be != 4'b0000);
  assign merged = lane_merge(reg_word, wd, be);

  assign led_we      = wr_en && (reg_off == OFF_LED_DUTY);
  assign rgb_we      = wr_en && (reg_off == OFF_RGB_DUTY);
  assign prescale_we = wr_en && (reg_off == OFF_PRESCALE);
  assign millis_we   = wr_en && (reg_off == OFF_MILLIS);

  // Load extraction from pre-store state, so a same-cycle store does not leak into the read
  assign lane_b = reg_word[{address[1:0], 3'b000} +: 8];
  assign lane_h = address[1] ? reg_word[31:16] : reg_word[15:0];

  always_comb begin
    read_data = '0;
    if (mem_read && hit) begin
      case (funct3)
        F3_LB:  read_data = {{24{lane_b[7]}}, lane_b};
        F3_LBU: read_data = {24'h0, lane_b};
        F3_LH:  if (!address[0]) read_data = {{16{lane_h[15]}}, lane_h};
        F3_LHU: if (!address[0]) read_data = {16'h0, lane_h};
        F3_LW:  if (address[1:0] == 2'b00) read_data = reg_word;
        default: read_data = '0;
      endcase
    end
  end

  // ">=" rather than "==" so a PRESCALE lowered below the running count wraps next edge
  assign pre_wrap  = (pre_cnt >= prescale_q);
  assign pwm_wrap  = pre_wrap && (pwm_cnt == 8'hFF);
  assign tick_wrap = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt    <= '0;
      pwm_cnt    <= '0;
      prescale_q <= '0;
      millis_q   <= '0;
      tick_cnt   <= '0;
    end else begin
      pre_cnt <= pre_wrap ? 16'h0 : pre_cnt + 16'd1;
      if (pre_wrap) pwm_cnt <= pwm_cnt + 8'd1;
      if (prescale_we) prescale_q <= merged[15:0];
      // A MILLIS store wins over a coinciding tick and restarts the millisecond
      if (millis_we) begin
        millis_q <= merged;
        tick_cnt <= '0;
      end else if (tick_wrap) begin
        millis_q <= millis_q + 32'd1;
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + 32'd1;
      end
    end
  end

  pwm_channel u_led (
    .clk(clk), .reset(reset), .duty_we(led_we), .duty_wdata(merged[7:0]),
    .wrap(pwm_wrap), .pwm_cnt(pwm_cnt), .shadow(led_shadow), .pwm_out(led)
  );

  pwm_channel u_red (
    .clk(clk), .reset(reset), .duty_we(rgb_we), .duty_wdata(merged[7:0]),
    .wrap(pwm_wrap), .pwm_cnt(pwm_cnt), .shadow(red_shadow), .pwm_out(red)
  );

  pwm_channel u_green (
    .clk(clk), .reset(reset), .duty_we(rgb_we), .duty_wdata(merged[15:8]),
    .wrap(pwm_wrap), .pwm_cnt(pwm_cnt), .shadow(green_shadow), .pwm_out(green)
  );

  pwm_channel u_blue (
    .clk(clk), .reset(reset), .duty_we(rgb_we), .duty_wdata(merged[23:16]),
    .wrap(pwm_wrap), .pwm_cnt(pwm_cnt), .shadow(blue_shadow), .pwm_out(blue)
  );

endmodule

// File: tb/tb_mmio_pwm_responder.sv
// Bench for mmio_pwm_responder: directed accesses, expectations queued at issue time and
// compared by a monitor at the falling edge whenever a load or an output probe is presented.
// Two instances share stimulus: default clock rate, and 4 kHz (tick every 4 cycles).
module tb_mmio_pwm_responder;
  import mmio_pkg::*;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] address = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] write_data = '0;

  logic [31:0] rd_a, rd_b;
  logic        led_a, red_a, green_a, blue_a;
  logic        led_b, red_b, green_b, blue_b;

  mmio_pwm_responder dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .funct3(funct3), .write_data(write_data), .read_data(rd_a),
    .led(led_a), .red(red_a), .green(green_a), .blue(blue_a)
  );

  mmio_pwm_responder #(.CLK_FREQ_HZ(4000)) dut_ms (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .funct3(funct3), .write_data(write_data), .read_data(rd_b),
    .led(led_b), .red(red_b), .green(green_b), .blue(blue_b)
  );

  always #5 clk = ~clk;

  // Reference step counter: with PRESCALE=0 the PWM step equals cycles since reset mod 256
  int cyc;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // kind: 0 = read_data (default), 1 = read_data (4 kHz), 2 = {led,red,green,blue}, 3 = {red,green,blue}
  typedef struct {
    string       name;
    logic [31:0] exp;
    int          kind;
  } exp_t;

  exp_t sb_q[$];
  logic probe = 1'b0;
  logic done = 1'b0;
  logic finished = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   wait_err = 0;

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    if (mem_read || probe) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL monitor: DUT sampled with empty scoreboard");
      end else begin
        e = sb_q.pop_front();
        case (e.kind)
          0:       act = rd_a;
          1:       act = rd_b;
          2:       act = {28'h0, led_a, red_a, green_a, blue_a};
          default: act = {29'h0, red_a, green_a, blue_a};
        endcase
        if (act === e.exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", e.name, act, e.exp, $time);
      end
    end else if (done && !finished) begin
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_checks++;
        $display("FAIL %s: never sampled, expected 0x%08h", e.name, e.exp);
      end
      n_checks += wait_err;
      finished = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string n, input logic [31:0] e, input int k);
    exp_t x;
    x.name = n;
    x.exp  = e;
    x.kind = k;
    sb_q.push_back(x);
  endtask

  task automatic do_probe(input string n, input logic [31:0] e, input int k);
    push(n, e, k);
    probe = 1'b1;
    step();
    probe = 1'b0;
  endtask

  task automatic do_load(input string n, input logic [7:0] off, input logic [2:0] f3,
                         input logic [31:0] e, input int k);
    address  = BASE | {24'h0, off};
    funct3   = f3;
    mem_read = 1'b1;
    push(n, e, k);
    step();
    mem_read = 1'b0;
  endtask

  task automatic do_store(input logic [7:0] off, input logic [2:0] f3, input logic [31:0] d);
    address    = BASE | {24'h0, off};
    funct3     = f3;
    write_data = d;
    mem_write  = 1'b1;
    step();
    mem_write  = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    int k = 0;
    while ((cyc % 256) != ph && k < 600) begin
      step();
      k++;
    end
    if ((cyc % 256) != ph) begin
      wait_err++;
      $display("FAIL wait_phase: step %0d not reached, at %0d", ph, cyc % 256);
    end
  endtask

  initial begin
    logic [2:0] bad_f3;
    bit         seen;
    int         wraps;
    int         p;
    logic       l_on, r_on, g_on, b_on;
    logic [7:0] ar, ag, ab;

    // Reset state
    step();
    do_load("reset_read_millis", OFF_MILLIS, F3_LW, 32'h0, 0);
    do_probe("reset_outputs", 32'h0, 2);
    reset = 1'b0;

    // Idle with PRESCALE=0 and zero duties
    for (int i = 0; i < 300; i++) begin
      if (i == 5) do_load("millis_after_5", OFF_MILLIS, F3_LW, 32'h0, 0);
      else        do_probe("idle_outputs", 32'h0, 2);
    end

    // LED duty 0x80: on for steps 0..127 from the first wrap after the store
    wait_phase(100);
    do_store(OFF_LED_DUTY, F3_SW, 32'h0000_0080);
    seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      p = cyc % 256;
      if (p == 0) seen = 1'b1;
      l_on = seen && (p < 128);
      do_probe("led_pwm", {28'h0, l_on, 3'b000}, 2);
    end

    // Byte/half lanes and extension
    do_store(8'h05, F3_SB, 32'h0000_00FF);
    do_load("lb_05",  8'h05, F3_LB,  32'hFFFF_FFFF, 0);
    do_load("lbu_05", 8'h05, F3_LBU, 32'h0000_00FF, 0);
    do_load("lw_04",  8'h04, F3_LW,  32'h0000_FF00, 0);
    do_load("lh_04",  8'h04, F3_LH,  32'hFFFF_FF00, 0);
    do_load("lhu_04", 8'h04, F3_LHU, 32'h0000_FF00, 0);
    do_load("lb_04",  8'h04, F3_LB,  32'h0000_0000, 0);

    // Ignored stores: misaligned, unmapped, unknown size
    bad_f3 = 3'b100;
    do_store(8'h01, F3_SH, 32'h0000_1234);
    do_store(8'h06, F3_SW, 32'hDEAD_BEEF);
    do_store(8'h10, F3_SW, 32'hFFFF_FFFF);
    do_store(8'h00, bad_f3, 32'h0000_0011);
    do_load("lw_02_misaligned", 8'h02, F3_LW, 32'h0, 0);
    do_load("lw_00_kept",       8'h00, F3_LW, 32'h0000_0080, 0);
    do_load("lw_04_kept",       8'h04, F3_LW, 32'h0000_FF00, 0);
    do_load("lw_10_unmapped",   8'h10, F3_LW, 32'h0, 0);
    do_load("lh_odd",           8'h05, F3_LH, 32'h0, 0);

    // Window miss and no-read
    address  = 32'hFFFF_FE00;
    funct3   = F3_LW;
    mem_read = 1'b1;
    push("miss_read", 32'h0, 0);
    step();
    mem_read = 1'b0;
    address  = BASE;
    do_probe("no_mem_read", 32'h0, 0);

    // Read and write together: load sees the pre-store value
    address    = BASE;
    funct3     = F3_SW;
    write_data = 32'h0000_0040;
    mem_read   = 1'b1;
    mem_write  = 1'b1;
    push("rw_old_value", 32'h0000_0080, 0);
    step();
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    do_load("rw_new_value", 8'h00, F3_LW, 32'h0000_0040, 0);

    // MILLIS on the 4 kHz instance: tick every 4 cycles
    do_store(OFF_MILLIS, F3_SW, 32'hFFFF_FFFF);
    do_load("millis_stored", OFF_MILLIS, F3_LW, 32'hFFFF_FFFF, 1);
    step();
    step();
    do_load("millis_pre_tick", OFF_MILLIS, F3_LW, 32'hFFFF_FFFF, 1);
    do_load("millis_wrapped",  OFF_MILLIS, F3_LW, 32'h0, 1);
    step();
    step();
    do_store(OFF_MILLIS, F3_SW, 32'h1234_5678);  // lands on the tick edge
    do_load("millis_store_on_tick", OFF_MILLIS, F3_LW, 32'h1234_5678, 1);
    do_load("millis_default_clk",   OFF_MILLIS, F3_LW, 32'h1234_5678, 0);
    do_store(8'h0D, F3_SB, 32'h0000_00AB);
    do_load("millis_sb",     OFF_MILLIS, F3_LW,  32'h1234_AB78, 1);
    do_load("millis_lhu_hi", 8'h0E,      F3_LHU, 32'h0000_1234, 1);

    // RGB write landing on the step-255 edge: old duty for one more period
    do_store(OFF_RGB_DUTY, F3_SW, 32'h0000_4020);
    wait_phase(255);
    do_store(OFF_RGB_DUTY, F3_SW, 32'h0010_80C0);
    wraps = 0;
    for (int i = 0; i < 600; i++) begin
      p = cyc % 256;
      if (p == 0) wraps++;
      ar = (wraps >= 2) ? 8'hC0 : 8'h20;
      ag = (wraps >= 2) ? 8'h80 : 8'h40;
      ab = (wraps >= 2) ? 8'h10 : 8'h00;
      r_on = (p < ar);
      g_on = (p < ag);
      b_on = (p < ab);
      do_probe("rgb_pwm", {29'h0, r_on, g_on, b_on}, 3);
    end

    // Reset mid-period with a store in the same cycle
    wait_phase(5);
    do_probe("rgb_before_reset", 32'h0000_0007, 3);
    reset      = 1'b1;
    address    = BASE;
    funct3     = F3_SW;
    write_data = 32'h0000_00AA;
    mem_write  = 1'b1;
    step();
    mem_write  = 1'b0;
    do_probe("reset_mid_outputs", 32'h0, 2);
    reset = 1'b0;
    do_load("led_after_reset",      OFF_LED_DUTY, F3_LW, 32'h0, 0);
    do_load("rgb_after_reset",      OFF_RGB_DUTY, F3_LW, 32'h0, 0);
    do_load("millis_after_reset",   OFF_MILLIS,   F3_LW, 32'h0, 0);
    do_load("prescale_after_reset", OFF_PRESCALE, F3_LW, 32'h0, 0);

    // PRESCALE keeps only 16 bits
    do_store(OFF_PRESCALE, F3_SW, 32'hFFFF_0003);
    do_load("prescale_bits", OFF_PRESCALE, F3_LW,  32'h0000_0003, 0);
    do_load("prescale_hi",   8'h0A,        F3_LHU, 32'h0, 0);

    done = 1'b1;
    for (int k = 0; k < 10 && !finished; k++) step();
    if (!finished) $fatal(1, "FAIL monitor: did not drain scoreboard");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
